hilo_div_ctrl: RTL and testbench
================================

# hilo_div_ctrl

Iterative 32-bit divide controller in the EX stage that sequences a radix-2 restoring divider and writes the quotient and remainder into the HI/LO register pair. It accepts a DIV/DIVU request from the EX stage and stalls the pipeline while busy. It issues a single-cycle HI/LO write-enable with the result, so it is the only multi-cycle writer of HI/LO. A pipeline flush can annul an operation in flight, and an annulled operation does not write HI/LO.

## Interface
- No parameters. Widths come from `RegBus` (32) and `DoubleRegBus` (64) in defines.v.
- clk       in   1   single clock; all state updates on its rising edge
- rst       in   1   synchronous, active-high reset (`RstEnable` = 1'b1)
- start_i   in   1   request a divide; sampled only in IDLE
- signed_i  in   1   1 = DIV (two's complement), 0 = DIVU; sampled with start_i
- opdata1_i in   32  dividend; sampled with start_i
- opdata2_i in   32  divisor; sampled with start_i
- annul_i   in   1   flush; cancels the operation in flight
- stall_o   out  1   pipeline stall request
- ready_o   out  1   result valid, high for exactly one cycle
- result_o  out  64  {remainder, quotient}; valid only while ready_o = 1
- hilo_we_o out  1   HI/LO write enable, equal to ready_o
- hi_o      out  32  remainder, wired to HI write data
- lo_o      out  32  quotient, wired to LO write data

## Operation
- States: IDLE, DIVZERO, BUSY, DONE.
- IDLE:
  - start_i=1 and annul_i=0 and opdata2_i=0 → DIVZERO.
  - start_i=1 and annul_i=0 and opdata2_i≠0 → BUSY. On this transition the block latches the operand magnitudes, the signs and signed_i, and clears the cycle counter.
  - Otherwise the block stays in IDLE.
- DIVZERO → DONE. The result is forced to 0 (hi=lo=0).
- BUSY: one restoring step per cycle.
  - 65-bit working register {rem[32:0], quo[31:0]}.
  - Each step: trial = rem[31:0],quo[31] minus {1'b0,divisor}. If the trial is non-negative, keep the difference and shift in 1. Otherwise shift in 0.
  - The counter runs 0..31. When the counter reaches 31 the state goes to DONE.
- DONE:
  - Apply signed fix-up when signed_i was latched 1. The quotient is negated if the operand signs differ. The remainder takes the sign of the dividend.
  - ready_o=hilo_we_o=1 for this one cycle, then the state returns to IDLE unconditionally.
- annul_i=1 in DIVZERO or BUSY → IDLE on the next edge. No write occurs and result_o returns to 0.
- annul_i=1 in DONE is ignored, because the write is already committed this cycle.
- Arithmetic:
  - Unsigned magnitudes are used internally.
  - 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000 (wraps) and remainder 0. This is not an error.
  - Divide-by-zero is not trapped.

## Timing
- Reset values: state=IDLE, stall_o=0, ready_o=0, hilo_we_o=0, result_o=hi_o=lo_o=0. The counter and the working register are cleared.
- Reset in any state returns the block to IDLE on that edge and suppresses any pending write.
- stall_o is combinational:
  - High in IDLE&start_i&!annul_i, in DIVZERO and in BUSY.
  - Low in DONE, so EX advances in the same cycle that HI/LO is written.
- Latency, start sampled in cycle 0:
  - Normal operation: BUSY in cycles 1–32, DONE/write in cycle 33, HI/LO visible from cycle 34.
  - Divide-by-zero: DIVZERO in cycle 1, DONE/write in cycle 2.
- Back-to-back operation: a start_i in the cycle after DONE is accepted normally. There is no dead cycle beyond DONE→IDLE.
- The operands may change after the start cycle. Only the latched copies are used.

## Structure
- defines.v gains the following macros:
  - State encodings `DivFree`, `DivByZero`, `DivOn`, `DivEnd` (2-bit).
  - `DivStart`/`DivStop`.
  - `DivResultReady`/`DivResultNotReady`.
- Sub-module `div_step` is combinational: it takes the 65-bit working register and the 32-bit divisor and returns the next working register. It keeps the FSM file compact and can be unit-tested on its own.
- The instantiating top connects hilo_we_o/hi_o/lo_o into the HI/LO register write port, muxed with the MTHI/MTLO/MULT path. The divider has priority on the cycle it writes.

## Test plan
- DIVU 100/7, start in cycle 0:
  - stall_o high in cycles 0–32.
  - In cycle 33: ready_o=hilo_we_o=1, hi_o=2, lo_o=14.
  - HI/LO read 2/14 in cycle 34.
- DIV −7/2 (0xFFFFFFF9 / 0x00000002): lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIV 7/−2: lo_o=0xFFFFFFFD, hi_o=1.
- DIV 0x80000000/0xFFFFFFFF: lo_o=0x80000000, hi_o=0, no hang. DIVU x/0: DONE in cycle 2 with hi_o=lo_o=0.
- Annul in cycle 10 of BUSY:
  - IDLE in cycle 11, hilo_we_o never asserts, stall_o low in cycle 11.
  - A new start in cycle 11 completes normally in cycle 44.
- rst asserted in cycle 15 of BUSY: all outputs 0 the next cycle, no write. A subsequent DIVU 9/3 gives hi=0, lo=3.
- Back-to-back DIVU 50/5 then 50/6 with start held high: two one-cycle writes, in cycle 33 (lo=10, hi=0) and in cycle 67 (lo=8, hi=2).

Source files
------------

// File: rtl/hilo_div_ctrl_pkg.sv
// Shared widths, FSM encoding and sign helper for the HI/LO divide controller.
package hilo_div_ctrl_pkg;

    localparam int unsigned REG_BUS        = 32;
    localparam int unsigned DOUBLE_REG_BUS = 64;
    // {rem[32:0], quo[31:0]}
    localparam int unsigned WORK_W         = 65;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    // Two's-complement negate when neg is set; used both for operand
    // magnitudes and for the final sign fix-up.
    function automatic logic [REG_BUS-1:0] neg_if(input logic neg, input logic [REG_BUS-1:0] v);
        return neg ? (~v + {{(REG_BUS-1){1'b0}}, 1'b1}) : v;
    endfunction

endpackage

// File: rtl/hilo_div_ctrl_div_step.sv
// One radix-2 restoring division step on the {rem, quo} working register.
module div_step
    import hilo_div_ctrl_pkg::*;
(
    input  logic [WORK_W-1:0]  i_work,
    input  logic [REG_BUS-1:0] i_divisor,
    output logic [WORK_W-1:0]  o_work
);

    logic [REG_BUS:0]   w_partial;
    logic [REG_BUS+1:0] w_diff;
    // rem[32] never becomes non-zero because rem always stays below the divisor
    logic               w_unused_msb;

    assign w_unused_msb = i_work[WORK_W-1];

    // Trial subtract of the divisor from {rem[31:0], quo[31]}; restore on borrow
    always_comb begin
        w_partial = i_work[WORK_W-2:REG_BUS-1];
        w_diff    = {1'b0, w_partial} - {2'b00, i_divisor};
        if (!w_diff[REG_BUS+1]) begin
            o_work = {w_diff[REG_BUS:0], i_work[REG_BUS-2:0], 1'b1};
        end else begin
            o_work = {w_partial, i_work[REG_BUS-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/hilo_div_ctrl.sv
// Iterative 32-bit DIV/DIVU controller; stalls EX while busy and issues a
// single-cycle HI/LO write with {remainder, quotient}.
module hilo_div_ctrl
    import hilo_div_ctrl_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    input  logic                        signed_i,
    input  logic [REG_BUS-1:0]          opdata1_i,
    input  logic [REG_BUS-1:0]          opdata2_i,
    input  logic                        annul_i,
    output logic                        stall_o,
    output logic                        ready_o,
    output logic [DOUBLE_REG_BUS-1:0]   result_o,
    output logic                        hilo_we_o,
    output logic [REG_BUS-1:0]          hi_o,
    output logic [REG_BUS-1:0]          lo_o
);

    div_state_e         r_state;
    div_state_e         w_next;
    logic [4:0]         r_cnt;
    logic [WORK_W-1:0]  r_work;
    logic [REG_BUS-1:0] r_divisor;
    logic               r_neg_quo;
    logic               r_neg_rem;

    logic [WORK_W-1:0]  w_work_next;
    logic [REG_BUS-1:0] w_quo;
    logic [REG_BUS-1:0] w_rem;
    logic               w_accept;
    logic               w_div_zero;

    assign w_accept   = (start_i == DIV_START) && !annul_i;
    assign w_div_zero = (opdata2_i == '0);

    div_step u_step (
        .i_work    (r_work),
        .i_divisor (r_divisor),
        .o_work    (w_work_next)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DIV_FREE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; annul only cancels before the write cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            DIV_FREE: begin
                if (w_accept) begin
                    w_next = w_div_zero ? DIV_BY_ZERO : DIV_ON;
                end
            end
            DIV_BY_ZERO: w_next = annul_i ? DIV_FREE : DIV_END;
            DIV_ON: begin
                if (annul_i) begin
                    w_next = DIV_FREE;
                end else if (r_cnt == 5'd31) begin
                    w_next = DIV_END;
                end
            end
            DIV_END:     w_next = DIV_FREE;
            default:     w_next = DIV_FREE;
        endcase
    end

    // Operand latch and per-cycle restoring step
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_work    <= '0;
            r_divisor <= '0;
            r_neg_quo <= 1'b0;
            r_neg_rem <= 1'b0;
        end else begin
            case (r_state)
                DIV_FREE: begin
                    if (w_accept) begin
                        r_cnt <= '0;
                        if (w_div_zero) begin
                            // Zero working register and sign flags give a 0/0 result
                            r_work    <= '0;
                            r_divisor <= '0;
                            r_neg_quo <= 1'b0;
                            r_neg_rem <= 1'b0;
                        end else begin
                            r_work    <= {{(WORK_W-REG_BUS){1'b0}},
                                          neg_if(signed_i & opdata1_i[REG_BUS-1], opdata1_i)};
                            r_divisor <= neg_if(signed_i & opdata2_i[REG_BUS-1], opdata2_i);
                            r_neg_quo <= signed_i & (opdata1_i[REG_BUS-1] ^ opdata2_i[REG_BUS-1]);
                            r_neg_rem <= signed_i & opdata1_i[REG_BUS-1];
                        end
                    end
                end
                DIV_ON: begin
                    r_work <= w_work_next;
                    r_cnt  <= r_cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end

    // Sign fix-up of the unsigned result: quotient by sign xor, remainder follows dividend
    always_comb begin
        w_quo = neg_if(r_neg_quo, r_work[REG_BUS-1:0]);
        w_rem = neg_if(r_neg_rem, r_work[DOUBLE_REG_BUS-1:REG_BUS]);
    end

    // Outputs: stall while accepting or computing, result only in DONE
    always_comb begin
        stall_o  = 1'b0;
        ready_o  = DIV_RESULT_NOT_READY;
        result_o = '0;
        case (r_state)
            DIV_FREE:    stall_o = w_accept;
            DIV_BY_ZERO: stall_o = 1'b1;
            DIV_ON:      stall_o = 1'b1;
            DIV_END: begin
                ready_o  = DIV_RESULT_READY;
                result_o = {w_rem, w_quo};
            end
            default: ;
        endcase
    end

    assign hilo_we_o = ready_o;
    assign hi_o      = result_o[DOUBLE_REG_BUS-1:REG_BUS];
    assign lo_o      = result_o[REG_BUS-1:0];

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed bench for hilo_div_ctrl: expected {hi,lo} pairs are queued when a
// divide is issued and compared when the controller signals ready.
module tb_hilo_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic        stall_o;
    logic        ready_o;
    logic [63:0] result_o;
    logic        hilo_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    hilo_div_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .signed_i  (signed_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .annul_i   (annul_i),
        .stall_o   (stall_o),
        .ready_o   (ready_o),
        .result_o  (result_o),
        .hilo_we_o (hilo_we_o),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err    = 0;
    int          we_pulses = 0;
    logic [63:0] exp_q[$];
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;

    // HI/LO register pair as the surrounding pipeline would hold it
    always @(posedge clk) begin
        if (rst) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (hilo_we_o) begin
            hi_reg <= hi_o;
            lo_reg <= lo_o;
        end
    end

    always @(negedge clk) begin
        if (hilo_we_o === 1'b1) we_pulses++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one divide at the current cycle (cycle 0) and follow it to the write
    task automatic run_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_lat);
        logic [63:0] e;
        int          cyc;
        bit          stall_ok;
        bit          got;
        start_i   = 1'b1;
        signed_i  = s;
        opdata1_i = a;
        opdata2_i = b;
        exp_q.push_back({exp_hi, exp_lo});
        cyc      = 0;
        stall_ok = 1'b1;
        got      = 1'b0;
        while (!got && cyc <= exp_lat + 4) begin
            @(negedge clk);
            if (ready_o === 1'b1) begin
                got = 1'b1;
            end else begin
                if (stall_o !== 1'b1) stall_ok = 1'b0;
                next_cycle();
                start_i   = 1'b0;
                signed_i  = $urandom_range(0, 1);
                opdata1_i = $urandom;
                opdata2_i = $urandom;
                cyc++;
            end
        end
        e = exp_q.pop_front();
        chk($sformatf("%s latency", tag), 64'(cyc), 64'(exp_lat));
        chk($sformatf("%s stall_busy", tag), {63'd0, stall_ok}, 64'd1);
        if (got) begin
            chk($sformatf("%s stall_done", tag), {63'd0, stall_o}, 64'd0);
            chk($sformatf("%s hilo_we", tag), {63'd0, hilo_we_o}, 64'd1);
            chk($sformatf("%s result", tag), result_o, e);
            chk($sformatf("%s hi_lo", tag), {hi_o, lo_o}, e);
        end
        next_cycle();
        start_i = 1'b0;
        @(negedge clk);
        chk($sformatf("%s ready_drop", tag), {63'd0, ready_o}, 64'd0);
        chk($sformatf("%s hilo_reg", tag), {hi_reg, lo_reg}, e);
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        int          sa, sb;
        int          saved_pulses;
        int          r1, r2, c;
        logic [63:0] e;

        rst       = 1'b1;
        start_i   = 1'b0;
        signed_i  = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        annul_i   = 1'b0;
        repeat (3) next_cycle();
        @(negedge clk);
        chk("rst stall", {63'd0, stall_o}, 64'd0);
        chk("rst ready", {63'd0, ready_o}, 64'd0);
        chk("rst we", {63'd0, hilo_we_o}, 64'd0);
        chk("rst result", result_o, 64'd0);
        chk("rst hilo", {hi_o, lo_o}, 64'd0);
        rst = 1'b0;
        next_cycle();

        run_op("divu100_7", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 33);
        run_op("div-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        run_op("div7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33);
        run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
        run_op("divu_by0", 1'b0, 32'd12345, 32'd0, 32'd0, 32'd0, 2);
        run_op("divu_max", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 33);

        for (int i = 0; i < 3; i++) begin
            a = $urandom;
            b = $urandom_range(1, 32'h0001_FFFF);
            run_op($sformatf("rand_u%0d", i), 1'b0, a, b, a % b, a / b, 33);
        end
        for (int i = 0; i < 3; i++) begin
            a  = $urandom;
            b  = $urandom_range(2, 32'h0000_FFFF);
            if (i == 1) b = -b;
            sa = a;
            sb = b;
            run_op($sformatf("rand_s%0d", i), 1'b1, a, b, 32'(sa % sb), 32'(sa / sb), 33);
        end

        // Annul in cycle 10 of BUSY, new start in cycle 11
        saved_pulses = we_pulses;
        start_i   = 1'b1;
        signed_i  = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        next_cycle();
        start_i = 1'b0;
        repeat (9) next_cycle();
        annul_i = 1'b1;
        @(negedge clk);
        chk("annul stall_c10", {63'd0, stall_o}, 64'd1);
        next_cycle();
        annul_i = 1'b0;
        #2;
        chk("annul stall_c11", {63'd0, stall_o}, 64'd0);
        chk("annul ready_c11", {63'd0, ready_o}, 64'd0);
        chk("annul no_write", 64'(we_pulses), 64'(saved_pulses));
        run_op("after_annul", 1'b0, 32'd77, 32'd5, 32'd2, 32'd15, 33);

        // Reset in cycle 15 of BUSY
        saved_pulses = we_pulses;
        start_i   = 1'b1;
        opdata1_i = 32'd12345;
        opdata2_i = 32'd67;
        next_cycle();
        start_i = 1'b0;
        repeat (14) next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy stall", {63'd0, stall_o}, 64'd0);
        chk("rst_busy ready", {63'd0, ready_o}, 64'd0);
        chk("rst_busy result", {hi_o, lo_o, result_o[63:0]} == '0 ? 64'd0 : 64'd1, 64'd0);
        next_cycle();
        chk("rst_busy no_write", 64'(we_pulses), 64'(saved_pulses));
        run_op("after_rst", 1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 33);

        // Back-to-back with start held high
        start_i   = 1'b1;
        signed_i  = 1'b0;
        opdata1_i = 32'd50;
        opdata2_i = 32'd5;
        exp_q.push_back({32'd0, 32'd10});
        exp_q.push_back({32'd2, 32'd8});
        r1 = -1;
        r2 = -1;
        c  = 0;
        while (r2 < 0 && c < 80) begin
            @(negedge clk);
            if (ready_o === 1'b1) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk($sformatf("b2b result_c%0d", c), result_o, e);
                end
                if (r1 < 0) begin
                    r1 = c;
                end else begin
                    r2 = c;
                    start_i = 1'b0;
                end
            end
            next_cycle();
            if (c == 0) opdata2_i = 32'd6;
            c++;
        end
        chk("b2b first_cycle", 64'(r1), 64'd33);
        chk("b2b second_cycle", 64'(r2), 64'd67);
        @(negedge clk);
        chk("b2b hilo_reg", {hi_reg, lo_reg}, {32'd2, 32'd8});
        chk("b2b idle", {62'd0, stall_o, ready_o}, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
